// File: rtl/regfile_sb_pkg.sv
// Shared constants for the pending-write register file: address/word widths,
// stack/heap pointer reset values and the sizing helper for retire counts.
package regfile_sb_pkg;

    localparam int DEF_LEN_REG_ADDR     = 5;
    localparam int DEF_LEN_WORD         = 32;
    localparam int DEF_LEN_MEMDATA_ADDR = 12;
    localparam logic [31:0] DEF_HEAP_POINTER_INIT = 32'h0000_2000;
    localparam int REG_SP = 2;
    localparam int REG_HP = 3;

    // Width needed to count 0..n_wr simultaneous retires on one register.
    function automatic int dec_width(input int n_wr);
        return (n_wr < 1) ? 1 : $clog2(n_wr + 1);
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Read/write/issue bundle of regfile_sb. master = core side, slave = register file.
interface regfile_sb_if #(
    parameter int LEN_WORD = 32,
    parameter int LEN_ADDR = 5,
    parameter int N_RD     = 2,
    parameter int N_WR     = 2
) ();
    logic [N_RD*LEN_ADDR-1:0] rd_addr;
    logic [N_RD*LEN_WORD-1:0] rd_data;
    logic [N_RD-1:0]          rd_busy;
    logic [N_WR-1:0]          wr_en;
    logic [N_WR*LEN_ADDR-1:0] wr_addr;
    logic [N_WR*LEN_WORD-1:0] wr_data;
    logic [N_WR-1:0]          wr_retire;
    logic                     iss_valid;
    logic [LEN_ADDR-1:0]      iss_rd;
    logic                     iss_ready;
    logic                     busy_any;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, wr_retire, iss_valid, iss_rd,
        input  rd_data, rd_busy, iss_ready, busy_any
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, wr_retire, iss_valid, iss_rd,
        output rd_data, rd_busy, iss_ready, busy_any
    );
endinterface

// File: rtl/regfile_sb_cnt.sv
// One saturating pending-writer counter (clamps at zero on over-retire).
// ASSERT_EN adds an underflow checker; REGFILE_BYPASS_EN exposes the next-state flag.
module regfile_sb_cnt #(
    parameter int CNT_W = 2,
    parameter int DEC_W = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc_i,
    input  logic [DEC_W-1:0] dec_i,
    output logic             nz_o,
    output logic             sat_o
`ifdef REGFILE_BYPASS_EN
    ,output logic            nz_next_o
`endif
);
    localparam int SW = ((CNT_W > DEC_W) ? CNT_W : DEC_W) + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SW-1:0]    sum_s;
    logic             under_s;

    // Net update: add the accepted issue, subtract retires, floor at zero.
    always_comb begin
        sum_s   = SW'(cnt_q) + SW'(inc_i);
        under_s = (sum_s < SW'(dec_i));
        if (under_s) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = CNT_W'(sum_s - SW'(dec_i));
        end
    end

    // Counter state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign nz_o  = |cnt_q;
    assign sat_o = &cnt_q;
`ifdef REGFILE_BYPASS_EN
    assign nz_next_o = rstn & (|cnt_d);
`endif

`ifdef ASSERT_EN
    regfile_sb_cnt_chk u_chk (.clk(clk), .rstn(rstn), .under_i(under_s));
`endif
endmodule

`ifdef ASSERT_EN
module regfile_sb_cnt_chk (
    input logic clk,
    input logic rstn,
    input logic under_i
);
    // Flag any retire that would take the counter below zero.
    always_ff @(posedge clk) begin
        assert (!(rstn && under_i)) else $error("regfile_sb_cnt: pending counter underflow");
    end
endmodule
`endif

// File: rtl/regfile_sb.sv
// Multi-port register file with per-register pending-writer scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int LEN_WORD = DEF_LEN_WORD,
    parameter int LEN_ADDR = DEF_LEN_REG_ADDR,
    parameter int N_RD     = 2,
    parameter int N_WR     = 2,
    parameter int CNT_W    = 2,
    parameter logic [LEN_WORD-1:0] INIT_R2 = LEN_WORD'(32'b100 << DEF_LEN_MEMDATA_ADDR),
    parameter logic [LEN_WORD-1:0] INIT_R3 = LEN_WORD'(DEF_HEAP_POINTER_INIT)
) (
    input logic         clk,
    input logic         rstn,
    regfile_sb_if.slave bus
);
    localparam int NREG  = 2**LEN_ADDR;
    localparam int DEC_W = dec_width(N_WR);

    logic [LEN_WORD-1:0] regs_q [NREG];
    logic [LEN_WORD-1:0] regs_d [NREG];
    logic [NREG-1:1]     inc_s;
    logic [DEC_W-1:0]    dec_s [1:NREG-1];
    logic [NREG-1:0]     nz_s;
    logic [NREG-1:0]     sat_s;
`ifdef REGFILE_BYPASS_EN
    logic [NREG-1:0]     nz_next_s;
    assign nz_next_s[0] = 1'b0;
`endif

    // Later write ports override earlier ones; x0 is never written.
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < N_WR; i++) begin
            if (bus.wr_en[i] && (bus.wr_addr[i*LEN_ADDR +: LEN_ADDR] != {LEN_ADDR{1'b0}})) begin
                regs_d[bus.wr_addr[i*LEN_ADDR +: LEN_ADDR]] = bus.wr_data[i*LEN_WORD +: LEN_WORD];
            end else begin
                regs_d[0] = {LEN_WORD{1'b0}};
            end
        end
        regs_d[0] = {LEN_WORD{1'b0}};
    end

    // Register array with stack/heap pointer reset values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= (r == REG_SP) ? INIT_R2 :
                             (r == REG_HP) ? INIT_R3 : {LEN_WORD{1'b0}};
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign bus.iss_ready = ~sat_s[bus.iss_rd];
    assign bus.busy_any  = |nz_s;
    assign nz_s[0]  = 1'b0;
    assign sat_s[0] = 1'b0;

    // Per-register issue increment and count of retiring write ports.
    always_comb begin
        for (int r = 1; r < NREG; r++) begin
            inc_s[r] = bus.iss_valid & bus.iss_ready & (bus.iss_rd == LEN_ADDR'(r));
            dec_s[r] = {DEC_W{1'b0}};
            for (int i = 0; i < N_WR; i++) begin
                if (bus.wr_en[i] && bus.wr_retire[i] &&
                    (bus.wr_addr[i*LEN_ADDR +: LEN_ADDR] == LEN_ADDR'(r))) begin
                    dec_s[r] = dec_s[r] + DEC_W'(1'b1);
                end else begin
                    dec_s[r] = dec_s[r];
                end
            end
        end
    end

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        regfile_sb_cnt #(.CNT_W(CNT_W), .DEC_W(DEC_W)) u_cnt (
            .clk   (clk),
            .rstn  (rstn),
            .inc_i (inc_s[r]),
            .dec_i (dec_s[r]),
            .nz_o  (nz_s[r]),
            .sat_o (sat_s[r])
`ifdef REGFILE_BYPASS_EN
            ,.nz_next_o (nz_next_s[r])
`endif
        );
    end

    // Combinational read ports, optionally forwarding same-cycle writes.
    always_comb begin
        bus.rd_data = {(N_RD*LEN_WORD){1'b0}};
        bus.rd_busy = {N_RD{1'b0}};
        for (int k = 0; k < N_RD; k++) begin
            logic [LEN_ADDR-1:0] ra;
            logic [LEN_WORD-1:0] rdat;
            logic                rbusy;
            ra    = bus.rd_addr[k*LEN_ADDR +: LEN_ADDR];
            rdat  = (ra == {LEN_ADDR{1'b0}}) ? {LEN_WORD{1'b0}} : regs_q[ra];
            rbusy = nz_s[ra];
`ifdef REGFILE_BYPASS_EN
            for (int i = 0; i < N_WR; i++) begin
                logic hit;
                hit   = bus.wr_en[i] && (bus.wr_addr[i*LEN_ADDR +: LEN_ADDR] == ra) &&
                        (ra != {LEN_ADDR{1'b0}});
                rdat  = hit ? bus.wr_data[i*LEN_WORD +: LEN_WORD] : rdat;
                rbusy = hit ? nz_next_s[ra] : rbusy;
            end
`endif
            bus.rd_data[k*LEN_WORD +: LEN_WORD] = rdat;
            bus.rd_busy[k] = rbusy;
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed plus randomized bench for regfile_sb against an array-based reference model.
module tb_regfile_sb;
    import regfile_sb_pkg::*;

    localparam int LW   = 32;
    localparam int LA   = 5;
    localparam int NR   = 2;
    localparam int NW   = 2;
    localparam int CW   = 2;
    localparam int NREG = 32;
    localparam int CMAX = 3;
    localparam logic [31:0] R2 = 32'b100 << DEF_LEN_MEMDATA_ADDR;
    localparam logic [31:0] R3 = DEF_HEAP_POINTER_INIT;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    regfile_sb_if #(.LEN_WORD(LW), .LEN_ADDR(LA), .N_RD(NR), .N_WR(NW)) bus ();

    regfile_sb #(.LEN_WORD(LW), .LEN_ADDR(LA), .N_RD(NR), .N_WR(NW), .CNT_W(CW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    logic [31:0] m_reg [NREG];
    int          m_cnt [NREG];
    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    function automatic int waddr(input int i);
        return int'(bus.wr_addr[i*LA +: LA]);
    endfunction

    function automatic logic [31:0] wdata(input int i);
        return bus.wr_data[i*LW +: LW];
    endfunction

    function automatic int next_cnt(input int r);
        int c;
        c = m_cnt[r];
        if (r != 0 && bus.iss_valid && int'(bus.iss_rd) == r && c != CMAX) c = c + 1;
        for (int i = 0; i < NW; i++)
            if (bus.wr_en[i] && bus.wr_retire[i] && waddr(i) == r) c = c - 1;
        if (c < 0) c = 0;
        return c;
    endfunction

    function automatic logic [31:0] exp_data(input int a);
        logic [31:0] d;
        if (a == 0) return 32'h0;
        d = m_reg[a];
`ifdef REGFILE_BYPASS_EN
        for (int i = 0; i < NW; i++)
            if (bus.wr_en[i] && waddr(i) == a) d = wdata(i);
`endif
        return d;
    endfunction

    function automatic logic exp_busy(input int a);
        logic b;
        if (a == 0) return 1'b0;
        b = (m_cnt[a] != 0);
`ifdef REGFILE_BYPASS_EN
        for (int i = 0; i < NW; i++)
            if (bus.wr_en[i] && waddr(i) == a) b = (next_cnt(a) != 0);
`endif
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        int  a;
        logic any;
        for (int k = 0; k < NR; k++) begin
            a = int'(bus.rd_addr[k*LA +: LA]);
            check($sformatf("%s.rd%0d_data(x%0d)", tag, k, a), bus.rd_data[k*LW +: LW], exp_data(a));
            check($sformatf("%s.rd%0d_busy(x%0d)", tag, k, a), {31'b0, bus.rd_busy[k]}, {31'b0, exp_busy(a)});
        end
        check({tag, ".iss_ready"}, {31'b0, bus.iss_ready},
              {31'b0, (bus.iss_rd == 5'd0) || (m_cnt[int'(bus.iss_rd)] != CMAX)});
        any = 1'b0;
        for (int r = 0; r < NREG; r++) any = any | (m_cnt[r] != 0);
        check({tag, ".busy_any"}, {31'b0, bus.busy_any}, {31'b0, any});
    endtask

    task automatic model_update();
        int nc [NREG];
        if (!rstn) begin
            for (int r = 0; r < NREG; r++) begin
                m_reg[r] = 32'h0;
                m_cnt[r] = 0;
            end
            m_reg[REG_SP] = R2;
            m_reg[REG_HP] = R3;
        end else begin
            for (int r = 0; r < NREG; r++) nc[r] = next_cnt(r);
            for (int i = 0; i < NW; i++)
                if (bus.wr_en[i] && waddr(i) != 0) m_reg[waddr(i)] = wdata(i);
            for (int r = 0; r < NREG; r++) m_cnt[r] = nc[r];
        end
    endtask

    task automatic tick(input string tag);
        if (rstn) begin
            @(negedge clk);
            check_outputs(tag);
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        bus.wr_en     = '0;
        bus.wr_retire = '0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.iss_valid = 1'b0;
        bus.iss_rd    = 5'd0;
    endtask

    task automatic set_rd(input int a0, input int a1);
        bus.rd_addr = {LA'(a1), LA'(a0)};
    endtask

    task automatic wr(input int p, input int a, input logic [31:0] d, input logic ret);
        bus.wr_en[p]             = 1'b1;
        bus.wr_addr[p*LA +: LA]  = LA'(a);
        bus.wr_data[p*LW +: LW]  = d;
        bus.wr_retire[p]         = ret;
    endtask

    task automatic issue(input int a);
        bus.iss_valid = 1'b1;
        bus.iss_rd    = LA'(a);
    endtask

    initial begin
        int pend [8];
        int a;
        idle();
        set_rd(0, 0);
        rstn = 1'b0;
        tick("rst");
        tick("rst");
        rstn = 1'b1;

        set_rd(0, 2);
        #1;
        check("reset_x0", bus.rd_data[31:0], 32'h0);
        check("reset_x2", bus.rd_data[63:32], R2);
        tick("reset_x0_x2");
        set_rd(3, 5);
        tick("reset_x3_x5");

        wr(0, 5, 32'hDEADBEEF, 1'b0);
        set_rd(5, 5);
        tick("wr_x5_same");
        idle();
        #1;
        check("x5_next", bus.rd_data[31:0], 32'hDEADBEEF);
        tick("wr_x5_next");

        wr(0, 7, 32'h11, 1'b0);
        wr(1, 7, 32'h22, 1'b0);
        set_rd(7, 0);
        tick("wr_x7_both");
        idle();
        wr(0, 0, 32'hFFFF, 1'b0);
        tick("wr_x0");
        idle();
        #1;
        check("x7_hi_port", bus.rd_data[31:0], 32'h22);
        check("x0_zero", bus.rd_data[63:32], 32'h0);
        tick("x7_x0");

        set_rd(9, 0);
        repeat (3) begin
            issue(9);
            tick("iss_x9");
        end
        issue(9);
        #1;
        check("x9_full_ready", {31'b0, bus.iss_ready}, 32'h0);
        check("x9_full_busy", {31'b0, bus.rd_busy[0]}, 32'h1);
        tick("iss_x9_ignored");
        idle();
        for (int i = 0; i < 3; i++) begin
            wr(0, 9, 32'(i + 100), 1'b1);
            tick("ret_x9");
        end
        idle();
        #1;
        check("x9_drained_busy", {31'b0, bus.rd_busy[0]}, 32'h0);
        check("x9_drained_any", {31'b0, bus.busy_any}, 32'h0);
        tick("x9_drained");

        set_rd(4, 0);
        issue(4);
        tick("iss_x4");
        idle();
        issue(4);
        wr(1, 4, 32'hAA, 1'b1);
        tick("x4_iss_ret");
        idle();
        #1;
        check("x4_still_busy", {31'b0, bus.rd_busy[0]}, 32'h1);
        wr(0, 4, 32'hBB, 1'b1);
        tick("x4_ret");
        idle();
        #1;
        check("x4_free", {31'b0, bus.rd_busy[0]}, 32'h0);
        tick("x4_done");

`ifndef ASSERT_EN
        set_rd(8, 0);
        wr(0, 8, 32'h1, 1'b1);
        wr(1, 8, 32'h2, 1'b1);
        tick("x8_underflow");
        idle();
        #1;
        check("x8_clamped", {31'b0, bus.rd_busy[0]}, 32'h0);
        tick("x8_clamp");
`endif

        set_rd(6, 2);
        issue(6);
        tick("iss_x6");
        wr(0, 6, 32'h1234, 1'b1);
        tick("wr_x6");
        idle();
        issue(6);
        wr(1, 6, 32'h55, 1'b1);
        rstn = 1'b0;
        tick("mid_rst");
        rstn = 1'b1;
        idle();
        #1;
        check("post_rst_x6", bus.rd_data[31:0], 32'h0);
        check("post_rst_x2", bus.rd_data[63:32], R2);
        check("post_rst_any", {31'b0, bus.busy_any}, 32'h0);
        tick("post_rst");
        set_rd(3, 6);
        tick("post_rst_x3");

        repeat (400) begin
            idle();
            rstn = ($urandom_range(0, 63) != 0);
            for (int j = 0; j < 8; j++) pend[j] = 0;
            for (int i = 0; i < NW; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    a = $urandom_range(0, 7);
                    wr(i, a, $urandom, 1'b0);
                    if ($urandom_range(0, 1) == 1 && m_cnt[a] > pend[a]) begin
                        bus.wr_retire[i] = 1'b1;
                        pend[a]++;
                    end
                end
            end
            if ($urandom_range(0, 2) != 0) issue($urandom_range(0, 7));
            set_rd($urandom_range(0, 7), $urandom_range(0, 7));
            tick("rand");
        end

        idle();
        rstn = 1'b1;
        tick("final");
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised multi-port integer register file with a per-register pending-write scoreboard. It replaces the single-write/dual-read register file in the core's decode/writeback path. Supports N_RD asynchronous read ports and N_WR synchronous write ports. Each register has an outstanding-writer counter so issue logic can stall on RAW/WAW hazards. x0 is hardwired to zero; x2 and x3 have parametrised reset values (stack/heap pointers).

Parameters:
LEN_WORD, 32, data width
LEN_ADDR, `LEN_REG_ADDR (5), register address width; register count NREG = 2**LEN_ADDR
N_RD, 2, number of read ports
N_WR, 2, number of write ports
CNT_W, 2, width of per-register pending counter; max outstanding writers = 2**CNT_W-1
INIT_R2, 32'b100 << `LEN_MEMDATA_ADDR, reset value of x2
INIT_R3, `HEAP_POINTER_INIT, reset value of x3

Ports:
clk  in  1  clock
rstn  in  1  synchronous reset, active-low
rd_addr  in  N_RD*LEN_ADDR  read addresses, port k at [k*LEN_ADDR +: LEN_ADDR]
rd_data  out  N_RD*LEN_WORD  read data, port k at [k*LEN_WORD +: LEN_WORD]
rd_busy  out  N_RD  1 when the addressed register has pending count != 0
wr_en  in  N_WR  write enable per port
wr_addr  in  N_WR*LEN_ADDR  write addresses
wr_data  in  N_WR*LEN_WORD  write data
wr_retire  in  N_WR  write also retires one pending writer (decrements counter)
iss_valid  in  1  issue of an instruction that will write iss_rd
iss_rd  in  LEN_ADDR  destination of issued instruction
iss_ready  out  1  0 when counter[iss_rd] is saturated
busy_any  out  1  OR of all nonzero counters (drain/flush indication)

Behaviour:
- Reset is synchronous, active-low, on clk. It sets all registers to 0 except x2=INIT_R2 and x3=INIT_R3. All counters are cleared. A reset mid-operation discards pending writes and issues in that cycle.
- Reads are combinational: rd_data = 0 if rd_addr==0, otherwise the register contents. rd_busy = 0 for x0.
- Writes land on posedge clk. Writes to x0 are ignored. If several ports write the same address in one cycle, the highest port index wins.
- Counter update per register r, per cycle:
  - inc = iss_valid & iss_ready & (iss_rd==r) & (r!=0)
  - dec = number of ports i with wr_en[i] & wr_retire[i] & wr_addr[i]==r
  - next = cnt + inc - dec
- Counter boundaries:
  - Decrement below 0 clamps at 0. Under `ASSERT_EN (global) this raises a $error.
  - iss_ready = (iss_rd==0) | (cnt[iss_rd] != 2**CNT_W-1). An issue with iss_ready=0 has no effect.
  - Issue and retire on the same register in the same cycle: the net count is applied. Example: 1 + 1 - 1 = 1, so the register stays busy.
- Outputs after reset: rd_data per reset contents, rd_busy=0, iss_ready=1, busy_any=0.
- Latency: write-to-read is 1 cycle without bypass (see Optional Feature). Counter update is visible the cycle after issue/retire.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: each read port compares against all same-cycle wr_en ports. On an address match (addr!=0), rd_data returns that wr_data (highest matching port wins) and rd_busy reflects the post-update counter. This gives 0-cycle write-to-read.
- Undefined: no comparators. Reads see only the stored value and the current counter. Same-cycle writes are visible next cycle.

Decomposition:
- Shared package/include (include.vh): `LEN_REG_ADDR, `LEN_WORD, `LEN_MEMDATA_ADDR, `HEAP_POINTER_INIT, and a new `REG_SP=2 and `REG_HP=3 index constant.
- One natural sub-module: regfile_sb_cnt, a single saturating pending counter (inc, dec count, clamp, nonzero flag). It is instantiated NREG-1 times via generate.
- Data array and bypass muxes stay in the top.

Test Plan:
- Reset then read x0,x2,x3,x5 -> 0, INIT_R2, INIT_R3, 0; rd_busy=0, busy_any=0, iss_ready=1.
- Write x5=0xDEADBEEF on port0, read x5 same cycle -> bypass build 0xDEADBEEF, non-bypass 0; next cycle both 0xDEADBEEF.
- Ports 0 and 1 both write x7 (0x11, 0x22) -> x7=0x22. A write to x0=0xFFFF leaves x0 reading 0.
- Issue x9 three times (CNT_W=2) -> rd_busy=1, iss_ready=0 for x9; a 4th issue is ignored; three retires -> rd_busy=0, busy_any=0.
- Same cycle: issue x4 and retire x4 with count=1 -> count stays 1, rd_busy=1; retire next cycle -> 0.
- Issue x6, write x6 with wr_retire=1, assert rstn=0 mid-sequence -> after reset x6=0, counters 0, x2/x3 restored.
